player_anim_sequencer: RTL and testbench
========================================

// Module: player_anim_sequencer
// PURPOSE
//  Per-player animation controller. Turns button/hit inputs into anim_state, anim_frame
//  and facing_right for the sprite mapper. Advances frames on video-frame ticks (vsync
//  pulse) and exposes an attack hitbox window for collision logic. One instance per player.
// PARAMETERS
//  TICKS_PER_FRAME  4   frame_tick pulses per animation frame (1..15)
//  IDLE_FRAMES     10   idle loop length
//  RUN_FRAMES       8   run loop length
//  ATK1_FRAMES     18   attack-1 one-shot length
//  HIT_TICKS       20   hitstun duration in frame_ticks (1..63)
//  HB_LO / HB_HI  7/11  attack frames (inclusive) with hitbox_active=1
// PORTS
//  clk           in   1  pixel/system clock
//  reset         in   1  synchronous, active-high
//  frame_tick    in   1  1-cycle pulse per video frame
//  move_left     in   1  level, debounced
//  move_right    in   1  level, debounced
//  attack_btn    in   1  level, debounced
//  hit_pulse     in   1  1-cycle pulse: player was struck
//  anim_state    out  4  0=IDLE 1=MOVE 3=ATK1 5=HIT (2,4 reserved, never driven)
//  anim_frame    out  6  frame index within current state
//  facing_right  out  1  1=right, 0=left
//  hitbox_active out  1  1 iff ATK1 && HB_LO<=anim_frame<=HB_HI
//  busy          out  1  1 in ATK1 or HIT (movement logic freezes pos_x)
// BEHAVIOUR
//  Reset: anim_state=IDLE, anim_frame=0, facing_right=1, hitbox_active=0, busy=0,
//   hold_cnt=0, hit_cnt=0, all pending flags cleared. Reset mid-attack/hitstun aborts immediately.
//  Edge capture (every clk): rising edge of attack_btn sets atk_pend; hit_pulse sets hit_pend.
//   Both consumed (cleared) on the next frame_tick, used or not. Holding attack_btn never repeats.
//  All outputs are registered, change only on the cycle after a frame_tick (1-clk latency).
//  hold_cnt: increments per tick; at TICKS_PER_FRAME-1 wraps to 0 and "adv" asserts.
//  Any state entry: anim_frame=0, hold_cnt=0.
//  Priority at each tick: hit_pend > state-specific rules below.
//  hit_pend: -> HIT, hit_cnt=0 (re-hit during HIT restarts hitstun).
//  IDLE/MOVE: atk_pend -> ATK1. Else exactly one of left/right -> MOVE, facing_right=move_right;
//   both or neither -> IDLE. Same-state: frame advances on adv, wraps N-1 -> 0.
//   MOVE->MOVE on direction reversal: facing flips, frame continues (no restart).
//  ATK1: frame advances on adv; on adv at frame ATK1_FRAMES-1 apply IDLE/MOVE rules
//   (atk_pend considered only per CONFIGURATION). Moves and facing ignored while in ATK1.
//  HIT: anim_frame held 0; hit_cnt increments per tick; at HIT_TICKS-1 apply IDLE/MOVE
//   rules with atk_pend ignored. Attack edges during HIT are discarded.
//  busy = (state==ATK1)||(state==HIT); hitbox_active registered with state/frame.
//  frame_tick and hit_pulse same cycle: hit_pend set, HIT entered on that same tick.
// CONFIGURATION
//  ATK_BUFFER_EN defined: attack edge arriving while anim_frame>=ATK1_FRAMES-4 in ATK1
//   sets atk_buf (survives tick clears); at attack end atk_buf -> ATK1 restart frame 0,
//   atk_buf cleared. Hit clears atk_buf.
//  Undefined: attack edges during ATK1 discarded; attack end always goes IDLE/MOVE.
// TESTING
//  1 reset, no input, 40 ticks -> IDLE, frames 0..9 each held 4 ticks, wraps 9->0 at tick 40.
//  2 move_left held from IDLE -> after next tick anim_state=1, facing_right=0; switch to
//    move_right at frame 5 -> facing_right=1, frame stays 5.
//  3 attack_btn pulse in IDLE -> ATK1 next tick; hitbox_active=1 exactly during frames 7..11
//    (20 ticks); after 72 ticks returns IDLE frame 0, busy 1->0.
//  4 hit_pulse at ATK1 frame 9 -> HIT next tick, hitbox_active=0, busy=1; second hit at
//    hit_cnt=10 -> hitstun restarts, IDLE 20 ticks after second hit.
//  5 attack_btn held continuously through attack end -> no second attack; with
//    ATK_BUFFER_EN, new edge at frame 15 -> ATK1 frame 0 directly after frame 17.
//  6 reset asserted mid-ATK1 frame 12 -> next clk all outputs at reset values.

Source files
------------

// File: rtl/player_anim_sequencer.sv
// ---------------------------------------------------------------------------
// player_anim_sequencer
//
// Per-player animation controller. Button and hit inputs are turned into an
// animation state, a frame index within that state and a facing direction for
// the sprite mapper. Everything advances on frame_tick (one pulse per video
// frame). An attack hitbox window is exposed for the collision logic.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high
//   frame_tick    in   1-cycle pulse per video frame
//   move_left     in   level, debounced
//   move_right    in   level, debounced
//   attack_btn    in   level, debounced (only rising edges start an attack)
//   hit_pulse     in   1-cycle pulse, player was struck
//   anim_state    out  0=IDLE 1=MOVE 3=ATK1 5=HIT
//   anim_frame    out  frame index within the current state
//   facing_right  out  1=right, 0=left
//   hitbox_active out  ATK1 and anim_frame within [HB_LO, HB_HI]
//   busy          out  ATK1 or HIT
//
// Optional feature macro: ATK_BUFFER_EN
//   Defined: an attack edge arriving in the last four attack frames is
//   buffered and chains directly into a fresh attack when the current one ends.
//   Undefined: attack edges during an attack are dropped.
// ---------------------------------------------------------------------------
module player_anim_sequencer #(
    parameter int TICKS_PER_FRAME = 4,
    parameter int IDLE_FRAMES     = 10,
    parameter int RUN_FRAMES      = 8,
    parameter int ATK1_FRAMES     = 18,
    parameter int HIT_TICKS       = 20,
    parameter int HB_LO           = 7,
    parameter int HB_HI           = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       attack_btn,
    input  logic       hit_pulse,
    output logic [3:0] anim_state,
    output logic [5:0] anim_frame,
    output logic       facing_right,
    output logic       hitbox_active,
    output logic       busy
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_MOVE = 4'd1,
        ST_ATK1 = 4'd3,
        ST_HIT  = 4'd5
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(TICKS_PER_FRAME - 1);
    localparam logic [5:0] IDLE_LAST = 6'(IDLE_FRAMES - 1);
    localparam logic [5:0] RUN_LAST  = 6'(RUN_FRAMES - 1);
    localparam logic [5:0] ATK_LAST  = 6'(ATK1_FRAMES - 1);
    localparam logic [5:0] HIT_LAST  = 6'(HIT_TICKS - 1);
    localparam logic [5:0] HB_FIRST  = 6'(HB_LO);
    localparam logic [5:0] HB_FINAL  = 6'(HB_HI);

    state_t     state, state_n;
    logic [5:0] frame_n;
    logic [3:0] hold_cnt, hold_n;
    logic [5:0] hit_cnt, hit_cnt_n;
    logic       facing_n;
    logic       atk_q;
    logic       atk_pend, atk_pend_n;
    logic       hit_pend, hit_pend_n;
    logic       atk_edge, atk_now, hit_now, adv, one_dir;
    state_t     ground_state;
    logic       ground_face;

`ifdef ATK_BUFFER_EN
    localparam logic [5:0] BUF_FIRST = 6'(ATK1_FRAMES - 4);
    logic atk_buf, atk_buf_n;
`endif

    assign anim_state = state;

    // Event qualifiers. A pulse that lands on the same cycle as frame_tick is
    // folded in directly so it is acted on by that tick instead of being lost
    // when the pending flags are cleared.
    always_comb begin
        atk_edge     = attack_btn & ~atk_q;
        atk_now      = atk_pend | atk_edge;
        hit_now      = hit_pend | hit_pulse;
        adv          = (hold_cnt == HOLD_LAST);
        one_dir      = move_left ^ move_right;
        ground_state = one_dir ? ST_MOVE : ST_IDLE;
        ground_face  = one_dir ? move_right : facing_right;
    end

    // Next-state logic. Nothing visible changes except on a frame_tick; on
    // other cycles only the pending-edge flags (and the attack buffer) update.
    always_comb begin
        state_n    = state;
        frame_n    = anim_frame;
        hold_n     = hold_cnt;
        hit_cnt_n  = hit_cnt;
        facing_n   = facing_right;
        atk_pend_n = atk_now;
        hit_pend_n = hit_now;
`ifdef ATK_BUFFER_EN
        atk_buf_n  = atk_buf;
        if (state == ST_ATK1 && atk_edge && anim_frame >= BUF_FIRST) begin
            atk_buf_n = 1'b1;
        end
`endif
        if (frame_tick) begin
            atk_pend_n = 1'b0;
            hit_pend_n = 1'b0;
            hold_n     = adv ? 4'd0 : hold_cnt + 4'd1;
            if (hit_now) begin
                // A hit always wins, and re-hits restart the hitstun.
                state_n   = ST_HIT;
                frame_n   = '0;
                hold_n    = '0;
                hit_cnt_n = '0;
`ifdef ATK_BUFFER_EN
                atk_buf_n = 1'b0;
`endif
            end else begin
                case (state)
                    ST_IDLE, ST_MOVE: begin
                        if (atk_now) begin
                            state_n = ST_ATK1;
                            frame_n = '0;
                            hold_n  = '0;
                        end else if (ground_state != state) begin
                            state_n  = ground_state;
                            facing_n = ground_face;
                            frame_n  = '0;
                            hold_n   = '0;
                        end else begin
                            // Staying put: a direction reversal in MOVE flips
                            // facing but keeps the run cycle going.
                            facing_n = ground_face;
                            if (adv) begin
                                if (anim_frame == ((state == ST_MOVE) ? RUN_LAST : IDLE_LAST)) begin
                                    frame_n = '0;
                                end else begin
                                    frame_n = anim_frame + 6'd1;
                                end
                            end
                        end
                    end
                    ST_ATK1: begin
                        if (adv) begin
                            if (anim_frame == ATK_LAST) begin
`ifdef ATK_BUFFER_EN
                                if (atk_buf_n) begin
                                    state_n   = ST_ATK1;
                                    atk_buf_n = 1'b0;
                                end else begin
                                    state_n  = ground_state;
                                    facing_n = ground_face;
                                end
`else
                                state_n  = ground_state;
                                facing_n = ground_face;
`endif
                                frame_n = '0;
                                hold_n  = '0;
                            end else begin
                                frame_n = anim_frame + 6'd1;
                            end
                        end
                    end
                    ST_HIT: begin
                        frame_n = '0;
                        if (hit_cnt == HIT_LAST) begin
                            state_n  = ground_state;
                            facing_n = ground_face;
                            hold_n   = '0;
                        end else begin
                            hit_cnt_n = hit_cnt + 6'd1;
                        end
                    end
                    default: begin
                        state_n = ST_IDLE;
                        frame_n = '0;
                        hold_n  = '0;
                    end
                endcase
            end
        end
    end

    // State and output registers. hitbox_active and busy are derived from the
    // next state so they line up with anim_state/anim_frame on the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            anim_frame    <= '0;
            hold_cnt      <= '0;
            hit_cnt       <= '0;
            facing_right  <= 1'b1;
            hitbox_active <= 1'b0;
            busy          <= 1'b0;
            atk_q         <= 1'b0;
            atk_pend      <= 1'b0;
            hit_pend      <= 1'b0;
`ifdef ATK_BUFFER_EN
            atk_buf       <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            anim_frame    <= frame_n;
            hold_cnt      <= hold_n;
            hit_cnt       <= hit_cnt_n;
            facing_right  <= facing_n;
            hitbox_active <= (state_n == ST_ATK1) && (frame_n >= HB_FIRST) && (frame_n <= HB_FINAL);
            busy          <= (state_n == ST_ATK1) || (state_n == ST_HIT);
            atk_q         <= attack_btn;
            atk_pend      <= atk_pend_n;
            hit_pend      <= hit_pend_n;
`ifdef ATK_BUFFER_EN
            atk_buf       <= atk_buf_n;
`endif
        end
    end

endmodule

// File: tb/tb_player_anim_sequencer.sv
// ---------------------------------------------------------------------------
// tb_player_anim_sequencer
//
// Self-checking bench for player_anim_sequencer. Expected output records are
// pushed to a scoreboard queue as each stimulus step is driven and popped
// and compared once the DUT has had its clock edge. A small table covers
// movement transitions; hand-written loops cover the multi-tick sequences
// (idle loop, run reversal, attack window, hitstun restart, held attack,
// mid-attack reset).
// ---------------------------------------------------------------------------
module tb_player_anim_sequencer;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_MOVE = 4'd1;
    localparam logic [3:0] S_ATK1 = 4'd3;
    localparam logic [3:0] S_HIT  = 4'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       move_left;
    logic       move_right;
    logic       attack_btn;
    logic       hit_pulse;
    logic [3:0] anim_state;
    logic [5:0] anim_frame;
    logic       facing_right;
    logic       hitbox_active;
    logic       busy;

    player_anim_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .move_left     (move_left),
        .move_right    (move_right),
        .attack_btn    (attack_btn),
        .hit_pulse     (hit_pulse),
        .anim_state    (anim_state),
        .anim_frame    (anim_frame),
        .facing_right  (facing_right),
        .hitbox_active (hitbox_active),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic [5:0] fr;
        logic       face;
        logic       hb;
        logic       bsy;
    } exp_t;

    typedef struct {
        logic       ml;
        logic       mr;
        logic [3:0] st;
        logic [5:0] fr;
        logic       face;
    } vec_t;

    exp_t sb_q[$];
    exp_t last_exp;
    exp_t rst_exp;
    vec_t vt[9];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [3:0] st, input int fr, input logic face);
        exp_t e;
        e.st   = st;
        e.fr   = 6'(fr);
        e.face = face;
        e.hb   = (st == S_ATK1) && (fr >= 7) && (fr <= 11);
        e.bsy  = (st == S_ATK1) || (st == S_HIT);
        return e;
    endfunction

    task automatic checkOutput(input string tag);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb_q.pop_front();
        if (anim_state !== e.st || anim_frame !== e.fr || facing_right !== e.face ||
            hitbox_active !== e.hb || busy !== e.bsy) begin
            errors++;
            $display("[TB] FAIL %s: got st=%0d fr=%0d face=%0b hb=%0b busy=%0b, want st=%0d fr=%0d face=%0b hb=%0b busy=%0b",
                     tag, anim_state, anim_frame, facing_right, hitbox_active, busy,
                     e.st, e.fr, e.face, e.hb, e.bsy);
        end
    endtask

    // One tick step: inputs settle for a non-tick cycle (outputs must hold),
    // then frame_tick pulses and the new expectation is checked.
    task automatic applyStimulus(input logic ml, input logic mr, input logic atk,
                                 input logic hit, input exp_t e, input string tag);
        move_left  = ml;
        move_right = mr;
        attack_btn = atk;
        hit_pulse  = hit;
        sb_q.push_back(last_exp);
        @(negedge clk);
        hit_pulse = 1'b0;
        checkOutput({tag, " hold"});
        frame_tick = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        frame_tick = 1'b0;
        checkOutput(tag);
        last_exp = e;
    endtask

    // hit_pulse coinciding with frame_tick.
    task automatic hitWithTick(input exp_t e, input string tag);
        move_left  = 1'b0;
        move_right = 1'b0;
        attack_btn = 1'b0;
        hit_pulse  = 1'b1;
        frame_tick = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        hit_pulse  = 1'b0;
        frame_tick = 1'b0;
        checkOutput(tag);
        last_exp = e;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        move_left  = 1'b0;
        move_right = 1'b0;
        attack_btn = 1'b0;
        hit_pulse  = 1'b0;
        rst_exp    = mk(S_IDLE, 0, 1'b1);

        vt[0] = '{1'b0, 1'b0, S_IDLE, 6'd0, 1'b1};
        vt[1] = '{1'b1, 1'b1, S_IDLE, 6'd0, 1'b1};
        vt[2] = '{1'b0, 1'b1, S_MOVE, 6'd0, 1'b1};
        vt[3] = '{1'b1, 1'b0, S_MOVE, 6'd0, 1'b0};
        vt[4] = '{1'b0, 1'b0, S_IDLE, 6'd0, 1'b0};
        vt[5] = '{1'b1, 1'b0, S_MOVE, 6'd0, 1'b0};
        vt[6] = '{1'b1, 1'b1, S_IDLE, 6'd0, 1'b0};
        vt[7] = '{1'b0, 1'b1, S_MOVE, 6'd0, 1'b1};
        vt[8] = '{1'b0, 1'b0, S_IDLE, 6'd0, 1'b1};

        @(negedge clk);
        @(negedge clk);
        sb_q.push_back(rst_exp);
        checkOutput("reset values");
        reset    = 1'b0;
        last_exp = rst_exp;

        $display("[TB] idle loop");
        for (int k = 1; k <= 40; k++)
            applyStimulus(0, 0, 0, 0, mk(S_IDLE, (k / 4) % 10, 1'b1), $sformatf("idle t%0d", k));

        $display("[TB] run with reversal");
        for (int k = 1; k <= 21; k++)
            applyStimulus(1, 0, 0, 0, mk(S_MOVE, ((k - 1) / 4) % 8, 1'b0), $sformatf("run left t%0d", k));
        for (int k = 22; k <= 25; k++)
            applyStimulus(0, 1, 0, 0, mk(S_MOVE, ((k - 1) / 4) % 8, 1'b1), $sformatf("run right t%0d", k));

        $display("[TB] movement table");
        for (int i = 0; i < 9; i++)
            applyStimulus(vt[i].ml, vt[i].mr, 0, 0, mk(vt[i].st, int'(vt[i].fr), vt[i].face),
                          $sformatf("table v%0d", i));

        $display("[TB] attack window");
        applyStimulus(0, 0, 1, 0, mk(S_ATK1, 0, 1'b1), "atk start");
        for (int j = 1; j <= 72; j++)
            applyStimulus(0, 0, 0, 0, (j < 72) ? mk(S_ATK1, j / 4, 1'b1) : mk(S_IDLE, 0, 1'b1),
                          $sformatf("atk t%0d", j));

        $display("[TB] held attack, moves ignored");
        applyStimulus(0, 0, 1, 0, mk(S_ATK1, 0, 1'b1), "held start");
        for (int j = 1; j <= 72; j++)
            applyStimulus(j >= 60, 0, 1, 0, (j < 72) ? mk(S_ATK1, j / 4, 1'b1) : mk(S_MOVE, 0, 1'b0),
                          $sformatf("held t%0d", j));
        for (int j = 73; j <= 76; j++)
            applyStimulus(1, 0, 1, 0, mk(S_MOVE, (j - 72) / 4, 1'b0), $sformatf("held run t%0d", j));
        applyStimulus(0, 0, 0, 0, mk(S_IDLE, 0, 1'b0), "held release");

        $display("[TB] late attack edge");
        applyStimulus(0, 0, 1, 0, mk(S_ATK1, 0, 1'b0), "late start");
        for (int j = 1; j < 72; j++)
            applyStimulus(0, 0, j == 61, 0, mk(S_ATK1, j / 4, 1'b0), $sformatf("late t%0d", j));
`ifdef ATK_BUFFER_EN
        applyStimulus(0, 0, 0, 0, mk(S_ATK1, 0, 1'b0), "late chain");
        for (int j = 1; j <= 72; j++)
            applyStimulus(0, 0, 0, 0, (j < 72) ? mk(S_ATK1, j / 4, 1'b0) : mk(S_IDLE, 0, 1'b0),
                          $sformatf("chain t%0d", j));
`else
        applyStimulus(0, 0, 0, 0, mk(S_IDLE, 0, 1'b0), "late dropped");
`endif

        $display("[TB] hit and hitstun restart");
        applyStimulus(0, 0, 1, 0, mk(S_ATK1, 0, 1'b0), "hit atk start");
        for (int j = 1; j <= 36; j++)
            applyStimulus(0, 0, 0, 0, mk(S_ATK1, j / 4, 1'b0), $sformatf("hit atk t%0d", j));
        applyStimulus(0, 0, 0, 1, mk(S_HIT, 0, 1'b0), "hit enter");
        for (int k = 1; k <= 10; k++)
            applyStimulus(0, 0, k == 5, 0, mk(S_HIT, 0, 1'b0), $sformatf("stun t%0d", k));
        hitWithTick(mk(S_HIT, 0, 1'b0), "rehit same tick");
        for (int k = 1; k <= 20; k++)
            applyStimulus(0, k >= 15, 0, 0, (k < 20) ? mk(S_HIT, 0, 1'b0) : mk(S_MOVE, 0, 1'b1),
                          $sformatf("restun t%0d", k));
        applyStimulus(0, 0, 0, 0, mk(S_IDLE, 0, 1'b1), "stun release");

        $display("[TB] reset mid attack");
        applyStimulus(1, 0, 0, 0, mk(S_MOVE, 0, 1'b0), "pre face left");
        applyStimulus(0, 0, 0, 0, mk(S_IDLE, 0, 1'b0), "pre idle");
        applyStimulus(0, 0, 1, 0, mk(S_ATK1, 0, 1'b0), "rst atk start");
        for (int j = 1; j <= 48; j++)
            applyStimulus(0, 0, 0, 0, mk(S_ATK1, j / 4, 1'b0), $sformatf("rst atk t%0d", j));
        attack_btn = 1'b0;
        reset      = 1'b1;
        hit_pulse  = 1'b1;
        sb_q.push_back(rst_exp);
        @(negedge clk);
        hit_pulse = 1'b0;
        checkOutput("reset mid attack");
        reset    = 1'b0;
        last_exp = rst_exp;
        for (int k = 1; k <= 8; k++)
            applyStimulus(0, 0, 0, 0, mk(S_IDLE, k / 4, 1'b1), $sformatf("post reset t%0d", k));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
